// File: rtl/jug_pkg.sv
// Shared types and defaults for the three-bucket pouring sequencer.
package jug_pkg;

  localparam int DEF_CAP_A = 8;
  localparam int DEF_CAP_B = 5;
  localparam int DEF_CAP_C = 3;
  localparam int LVL_W     = 4;

  typedef logic [LVL_W-1:0] lvl_t;

  typedef enum logic [1:0] {
    BKT_A       = 2'd0,
    BKT_B       = 2'd1,
    BKT_C       = 2'd2,
    BKT_ILLEGAL = 2'd3
  } bucket_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POUR = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic lvl_t pick_lvl(input bucket_e sel, input lvl_t a,
                                    input lvl_t b, input lvl_t c);
    lvl_t r;
    case (sel)
      BKT_A:   r = a;
      BKT_B:   r = b;
      BKT_C:   r = c;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jug_xfer_calc.sv
// Pour amount: whatever the source holds, limited by the room left in the destination.
module jug_xfer_calc
  import jug_pkg::*;
(
  input  logic [LVL_W-1:0] src_lvl,
  input  logic [LVL_W-1:0] dst_lvl,
  input  logic [LVL_W-1:0] dst_cap,
  output logic [LVL_W-1:0] amt
);

  lvl_t room;

  always_comb begin
    room = dst_cap - dst_lvl;
    amt  = (src_lvl < room) ? src_lvl : room;
  end

endmodule

// File: rtl/jug_pour_seq.sv
// Water-jug pour sequencer: accepts src/dst commands and moves one unit per cycle.
module jug_pour_seq
  import jug_pkg::*;
#(
  parameter int CAP_A = DEF_CAP_A,
  parameter int CAP_B = DEF_CAP_B,
  parameter int CAP_C = DEF_CAP_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_src,
  input  logic [1:0]       cmd_dst,
  input  logic [LVL_W-1:0] target,
  output logic [LVL_W-1:0] lvl_a,
  output logic [LVL_W-1:0] lvl_b,
  output logic [LVL_W-1:0] lvl_c,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             goal,
  output logic             goal_seen,
  output logic [7:0]       step_cnt
);

  localparam lvl_t CAP_A_L = lvl_t'(CAP_A);
  localparam lvl_t CAP_B_L = lvl_t'(CAP_B);
  localparam lvl_t CAP_C_L = lvl_t'(CAP_C);

  state_e  state, state_d;
  bucket_e src_q, dst_q, src_d, dst_d;
  lvl_t    rem, rem_d;
  lvl_t    lvl_a_d, lvl_b_d, lvl_c_d;
  lvl_t    sel_src_lvl, sel_dst_lvl, sel_dst_cap, amt;
  logic    accept, illegal, err_d;

  always_comb begin
    sel_src_lvl = pick_lvl(bucket_e'(cmd_src), lvl_a, lvl_b, lvl_c);
    sel_dst_lvl = pick_lvl(bucket_e'(cmd_dst), lvl_a, lvl_b, lvl_c);
    sel_dst_cap = pick_lvl(bucket_e'(cmd_dst), CAP_A_L, CAP_B_L, CAP_C_L);
  end

  jug_xfer_calc u_calc (
    .src_lvl (sel_src_lvl),
    .dst_lvl (sel_dst_lvl),
    .dst_cap (sel_dst_cap),
    .amt     (amt)
  );

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign illegal   = (cmd_src == cmd_dst) || (cmd_src == BKT_ILLEGAL) ||
                     (cmd_dst == BKT_ILLEGAL);
  assign goal      = (lvl_a == target) || (lvl_b == target) || (lvl_c == target);

  // A zero-amount command still spends one POUR cycle (rem=0) so DONE always
  // lands max(amt,1) edges after acceptance.
  always_comb begin
    state_d = state;
    rem_d   = rem;
    src_d   = src_q;
    dst_d   = dst_q;
    lvl_a_d = lvl_a;
    lvl_b_d = lvl_b;
    lvl_c_d = lvl_c;
    err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            src_d   = bucket_e'(cmd_src);
            dst_d   = bucket_e'(cmd_dst);
            rem_d   = amt;
            state_d = ST_POUR;
          end
        end
      end
      ST_POUR: begin
        if (rem == '0) begin
          state_d = ST_DONE;
        end else begin
          case (src_q)
            BKT_A:   lvl_a_d = lvl_a - lvl_t'(1);
            BKT_B:   lvl_b_d = lvl_b - lvl_t'(1);
            BKT_C:   lvl_c_d = lvl_c - lvl_t'(1);
            default: ;
          endcase
          case (dst_q)
            BKT_A:   lvl_a_d = lvl_a + lvl_t'(1);
            BKT_B:   lvl_b_d = lvl_b + lvl_t'(1);
            BKT_C:   lvl_c_d = lvl_c + lvl_t'(1);
            default: ;
          endcase
          rem_d = rem - lvl_t'(1);
          if (rem == lvl_t'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rem       <= '0;
      src_q     <= BKT_A;
      dst_q     <= BKT_A;
      lvl_a     <= CAP_A_L;
      lvl_b     <= '0;
      lvl_c     <= '0;
      err       <= 1'b0;
      goal_seen <= 1'b0;
      step_cnt  <= '0;
    end else begin
      state     <= state_d;
      rem       <= rem_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      lvl_a     <= lvl_a_d;
      lvl_b     <= lvl_b_d;
      lvl_c     <= lvl_c_d;
      err       <= err_d;
      goal_seen <= goal_seen | goal;
      if ((state == ST_DONE) && (step_cnt != 8'hFF)) step_cnt <= step_cnt + 8'd1;
    end
  end

endmodule
